// File: rtl/spectrum_peak_hold_pkg.sv
// spectrum_peak_hold_pkg: shared sizes, state encoding and height/hold types for the spectrum display path.
package spectrum_peak_hold_pkg;
  localparam int N = 256;
  localparam int WIDTH = 18;
  localparam int N_BARS = 64;
  localparam int BIN_OFFSET = 1;
  localparam int SHIFT = 6;
  localparam int MAX_HEIGHT = 480;
  localparam int HOLD_FRAMES = 30;
  localparam int DECAY = 4;
  localparam int HEIGHT_BITS = 10;
  localparam int CW = $clog2(HOLD_FRAMES + 1);
  localparam int IW = $clog2(N_BARS);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  typedef logic [HEIGHT_BITS-1:0] height_t;
  typedef logic [CW-1:0] hold_t;
endpackage

// File: rtl/spectrum_peak_hold_if.sv
// spectrum_peak_hold_if: FFT magnitude input and committed bar/peak frame output.
interface spectrum_peak_hold_if import spectrum_peak_hold_pkg::*; ;
  logic fft_done;
  logic [WIDTH:0] freq_samples [N];
  height_t bar_height [N_BARS];
  height_t peak_height [N_BARS];
  logic frame_valid;
  logic busy;
  modport master (output fft_done, freq_samples, input bar_height, peak_height, frame_valid, busy);
  modport slave (input fft_done, freq_samples, output bar_height, peak_height, frame_valid, busy);
endinterface

// File: rtl/spectrum_peak_hold_cell.sv
// spectrum_peak_hold_cell: next peak marker and hold counter for one bar given its new height.
module spectrum_peak_hold_cell import spectrum_peak_hold_pkg::*; (
  input  height_t h,
  input  height_t p,
  input  hold_t   c,
  output height_t p_n,
  output hold_t   c_n
);
  logic [HEIGHT_BITS:0] floor_v;
  logic decay_ok;
  always_comb begin
    floor_v = {1'b0, h} + (HEIGHT_BITS + 1)'(DECAY);
    // decay only while it stays at or above h; this also keeps p from wrapping below 0
    decay_ok = {1'b0, p} >= floor_v;
    p_n = h >= p ? h : c != '0 ? p : decay_ok ? p - HEIGHT_BITS'(DECAY) : h;
    c_n = h >= p ? hold_t'(HOLD_FRAMES) : c != '0 ? c - hold_t'(1) : c;
  end
endmodule

// File: rtl/spectrum_peak_hold.sv
// spectrum_peak_hold: scans FFT bins into saturated bar heights with peak-hold markers, committing whole frames.
module spectrum_peak_hold import spectrum_peak_hold_pkg::*; (
  input logic clk_25MHz,
  input logic rst,
  spectrum_peak_hold_if.slave bus
);
  localparam int BW = $clog2(N);
  state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [IW-1:0] k_q, k_d;
  logic pend_q, pend_d, fv_q, fv_d, busy_q, busy_d, trig;
  height_t bar_q [N_BARS], bar_d [N_BARS], peak_q [N_BARS], peak_d [N_BARS];
  height_t bar_out_q [N_BARS], bar_out_d [N_BARS], peak_out_q [N_BARS], peak_out_d [N_BARS];
  hold_t cnt_q [N_BARS], cnt_d [N_BARS];
  logic [WIDTH:0] mag;
  logic [BW-1:0] bin;
  height_t h, p_n;
  hold_t c_n;
  spectrum_peak_hold_cell u_cell (.h(h), .p(peak_q[k_q]), .c(cnt_q[k_q]), .p_n(p_n), .c_n(c_n));
  always_comb begin
    sync_d = {sync_q[1:0], bus.fft_done};
    trig = sync_q[1] & ~sync_q[2];
    bin = BW'(BIN_OFFSET) + BW'(k_q);
    mag = bus.freq_samples[bin] >> SHIFT;
    h = mag > (WIDTH + 1)'(MAX_HEIGHT) ? HEIGHT_BITS'(MAX_HEIGHT) : mag[HEIGHT_BITS-1:0];
    state_d = state_q;
    k_d = k_q;
    pend_d = pend_q;
    fv_d = 1'b0;
    bar_d = bar_q;
    peak_d = peak_q;
    cnt_d = cnt_q;
    bar_out_d = bar_out_q;
    peak_out_d = peak_out_q;
    if (state_q == IDLE) begin
      state_d = trig ? SCAN : IDLE;
      k_d = '0;
    end else if (state_q == SCAN) begin
      bar_d[k_q] = h;
      peak_d[k_q] = p_n;
      cnt_d[k_q] = c_n;
      k_d = k_q + IW'(1);
      pend_d = pend_q | trig;
      state_d = k_q == IW'(N_BARS - 1) ? COMMIT : SCAN;
    end else begin
      // all bars land together so the display never sees a torn frame
      bar_out_d = bar_q;
      peak_out_d = peak_q;
      fv_d = 1'b1;
      state_d = pend_q | trig ? SCAN : IDLE;
      pend_d = 1'b0;
      k_d = '0;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      k_q <= '0;
      pend_q <= 1'b0;
      fv_q <= 1'b0;
      busy_q <= 1'b0;
      bar_q <= '{default: '0};
      peak_q <= '{default: '0};
      cnt_q <= '{default: '0};
      bar_out_q <= '{default: '0};
      peak_out_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      k_q <= k_d;
      pend_q <= pend_d;
      fv_q <= fv_d;
      busy_q <= busy_d;
      bar_q <= bar_d;
      peak_q <= peak_d;
      cnt_q <= cnt_d;
      bar_out_q <= bar_out_d;
      peak_out_q <= peak_out_d;
    end
  end
  assign bus.bar_height = bar_out_q;
  assign bus.peak_height = peak_out_q;
  assign bus.frame_valid = fv_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_spectrum_peak_hold.sv
// tb_spectrum_peak_hold: directed frames against a scoreboard of expected bar/peak frames.
module tb_spectrum_peak_hold;
  import spectrum_peak_hold_pkg::*;
  localparam int HB = HEIGHT_BITS;
  localparam int PW = N_BARS * HB;
  typedef struct packed {logic [PW-1:0] bars; logic [PW-1:0] peaks;} frame_t;
  logic clk_25MHz = 1'b0;
  logic rst = 1'b0;
  int total = 0, bad = 0, fv_count = 0;
  int m_peak [N_BARS];
  int m_cnt [N_BARS];
  frame_t exp_q [$];
  always #20 clk_25MHz = ~clk_25MHz;
  spectrum_peak_hold_if bus ();
  spectrum_peak_hold dut (.clk_25MHz(clk_25MHz), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] obs_bars();
    logic [PW-1:0] v;
    for (int i = 0; i < N_BARS; i++) v[i*HB +: HB] = bus.bar_height[i];
    return v;
  endfunction

  function automatic logic [PW-1:0] obs_peaks();
    logic [PW-1:0] v;
    for (int i = 0; i < N_BARS; i++) v[i*HB +: HB] = bus.peak_height[i];
    return v;
  endfunction

  always @(negedge clk_25MHz) begin
    if (bus.frame_valid === 1'b1) begin
      frame_t e;
      fv_count++;
      check("frame_expected", PW'(exp_q.size() != 0), PW'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_bars", obs_bars(), e.bars);
        check("sb_peaks", obs_peaks(), e.peaks);
      end
    end
  end

  task automatic push_frame();
    frame_t e;
    int h, p, c;
    for (int k = 0; k < N_BARS; k++) begin
      h = int'(bus.freq_samples[BIN_OFFSET + k] >> SHIFT);
      if (h > MAX_HEIGHT) h = MAX_HEIGHT;
      p = m_peak[k];
      c = m_cnt[k];
      if (h >= p) begin p = h; c = HOLD_FRAMES; end
      else if (c != 0) c = c - 1;
      else p = (p - DECAY > h) ? p - DECAY : h;
      m_peak[k] = p;
      m_cnt[k] = c;
      e.bars[k*HB +: HB] = HB'(h);
      e.peaks[k*HB +: HB] = HB'(p);
    end
    exp_q.push_back(e);
  endtask

  task automatic set_bins(input int b1, input int b2, input int b3, input int b4, input int b5);
    for (int i = 0; i < N; i++) bus.freq_samples[i] = '0;
    bus.freq_samples[1] = (WIDTH + 1)'(b1);
    bus.freq_samples[2] = (WIDTH + 1)'(b2);
    bus.freq_samples[3] = (WIDTH + 1)'(b3);
    bus.freq_samples[4] = (WIDTH + 1)'(b4);
    bus.freq_samples[5] = (WIDTH + 1)'(b5);
  endtask

  task automatic rise(input bit expect_frame);
    @(posedge clk_25MHz);
    #1 bus.fft_done = 1'b1;
    if (expect_frame) push_frame();
  endtask

  task automatic fall();
    @(posedge clk_25MHz);
    #1 bus.fft_done = 1'b0;
  endtask

  task automatic wait_fv(output int cyc, output int bc);
    cyc = 0;
    bc = 0;
    do begin
      @(posedge clk_25MHz);
      cyc++;
      @(negedge clk_25MHz);
      if (bus.busy === 1'b1) bc++;
    end while (bus.frame_valid !== 1'b1 && cyc < 200);
    check("frame_seen", PW'(bus.frame_valid), PW'(1));
  endtask

  task automatic run_frame();
    int cyc, bc;
    rise(1'b1);
    wait_fv(cyc, bc);
  endtask

  initial begin
    int cyc, bc, fv0, e1, e3, e4;
    bus.fft_done = 1'b0;
    for (int k = 0; k < N_BARS; k++) begin m_peak[k] = 0; m_cnt[k] = 0; end
    set_bins(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk_25MHz);
    #1 bus.fft_done = 1'b1;
    repeat (5) @(posedge clk_25MHz);
    #1 bus.fft_done = 1'b0;
    repeat (5) @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    check("rst_bars", obs_bars(), '0);
    check("rst_peaks", obs_peaks(), '0);
    check("rst_busy", PW'(bus.busy), '0);
    check("rst_no_fv", PW'(fv_count), '0);
    @(posedge clk_25MHz);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    check("post_rst_bars", obs_bars(), '0);
    check("post_rst_no_fv", PW'(fv_count), '0);

    set_bins(32'h3FFFF, 640, 63, 0, 0);
    rise(1'b1);
    wait_fv(cyc, bc);
    check("latency", PW'(cyc), PW'(68));
    check("busy_cycles", PW'(bc), PW'(65));
    check("bar0_sat", PW'(bus.bar_height[0]), PW'(480));
    check("bar1", PW'(bus.bar_height[1]), PW'(10));
    check("bar2", PW'(bus.bar_height[2]), PW'(0));
    check("peak0", PW'(bus.peak_height[0]), PW'(480));
    check("peak1", PW'(bus.peak_height[1]), PW'(10));
    check("peak2", PW'(bus.peak_height[2]), PW'(0));
    fall();
    repeat (5) @(posedge clk_25MHz);

    fv0 = fv_count;
    set_bins(1000, 2000, 3000, 0, 0);
    rise(1'b1);
    repeat (10) @(posedge clk_25MHz);
    fall();
    repeat (12) @(posedge clk_25MHz);
    rise(1'b1);
    repeat (10) @(posedge clk_25MHz);
    fall();
    repeat (10) @(posedge clk_25MHz);
    rise(1'b0);
    repeat (250) @(posedge clk_25MHz);
    fall();
    repeat (5) @(posedge clk_25MHz);
    check("b2b_pulses", PW'(fv_count - fv0), PW'(2));
    check("b2b_sb_empty", PW'(exp_q.size()), '0);

    for (int f = 0; f <= 35; f++) begin
      set_bins(0, f == 0 ? 6400 : 0, 0, f == 0 ? 320 : 0, f == 0 ? 6400 : f <= 30 ? 0 : 6272);
      run_frame();
      e1 = f <= 30 ? 100 : 100 - DECAY * (f - 30);
      e3 = f <= 30 ? 5 : f == 31 ? 1 : 0;
      e4 = f <= 30 ? 100 : 98;
      check($sformatf("hold_peak1_f%0d", f), PW'(bus.peak_height[1]), PW'(e1));
      check($sformatf("floor_peak3_f%0d", f), PW'(bus.peak_height[3]), PW'(e3));
      check($sformatf("floor_peak4_f%0d", f), PW'(bus.peak_height[4]), PW'(e4));
      fall();
      repeat (4) @(posedge clk_25MHz);
    end

    fv0 = fv_count;
    set_bins(0, 640, 0, 0, 1280);
    rise(1'b1);
    repeat (33) @(posedge clk_25MHz);
    #1 rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < N_BARS; k++) begin m_peak[k] = 0; m_cnt[k] = 0; end
    bus.fft_done = 1'b0;
    repeat (5) @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    check("midrst_bars", obs_bars(), '0);
    check("midrst_peaks", obs_peaks(), '0);
    check("midrst_busy", PW'(bus.busy), '0);
    @(posedge clk_25MHz);
    #1 rst = 1'b1;
    repeat (80) @(posedge clk_25MHz);
    check("midrst_no_fv", PW'(fv_count - fv0), '0);
    run_frame();
    check("fresh_bar1", PW'(bus.bar_height[1]), PW'(10));
    check("fresh_peak1", PW'(bus.peak_height[1]), PW'(10));
    check("fresh_peak4", PW'(bus.peak_height[4]), PW'(20));
    fall();
    repeat (5) @(posedge clk_25MHz);
    check("final_sb_empty", PW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
